// File: rtl/reg_wb_arbiter.sv
// Round-robin writeback arbiter sharing the register bank's single write port among NREQ sources.
// Supports port locking for multi-register bursts; the winning beat is registered onto wrReg/rd/rdIn.
module reg_wb_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_en,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_lock,
  input  logic [NREQ*ADDR_W-1:0]   req_rd,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     wrReg,
  output logic [ADDR_W-1:0]        rd,
  output logic [DATA_W-1:0]        rdIn,
  output logic [2:0]               grant_id,
  output logic [2**ADDR_W-1:0]     pend_mask
);

  localparam int unsigned PendW = 2**ADDR_W;

  typedef enum logic [0:0] {StArb, StLock} state_e;

  state_e              state_q, state_d;
  logic [2:0]          rr_ptr_q, rr_ptr_d;
  logic [2:0]          lock_id_q, lock_id_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [2:0]          gid_q, gid_d;

  logic                grant_vld;
  logic [2:0]          grant_idx;
  logic [3:0]          scan_idx;
  logic [7:0]          valid_ext;
  logic [7:0]          lock_ext;
  logic [ADDR_W-1:0]   sel_rd;
  logic [DATA_W-1:0]   sel_data;

  // Widened copies so a 3-bit index is always in range regardless of NREQ.
  assign valid_ext = 8'(req_valid);
  assign lock_ext  = 8'(req_lock);

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    if (wb_en && !reset) begin
      if (state_q == StLock) begin
        grant_vld = valid_ext[lock_id_q];
        grant_idx = lock_id_q;
      end else begin
        // Scan from the far end back to rr_ptr so the last hit is the first in RR order.
        for (int k = NREQ - 1; k >= 0; k--) begin
          scan_idx = {1'b0, rr_ptr_q} + 4'(k);
          if (scan_idx >= 4'(NREQ)) scan_idx = scan_idx - 4'(NREQ);
          if (valid_ext[scan_idx[2:0]]) begin
            grant_vld = 1'b1;
            grant_idx = scan_idx[2:0];
          end
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_rd    = '0;
    sel_data  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == 3'(k)) begin
        req_ready[k] = grant_vld;
        sel_rd       = req_rd[k*ADDR_W +: ADDR_W];
        sel_data     = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    wr_d      = 1'b0;
    rd_d      = rd_q;
    data_d    = data_q;
    gid_d     = gid_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == 3'(NREQ - 1)) ? 3'd0 : grant_idx + 3'd1;
      gid_d    = grant_idx;
      rd_d     = sel_rd;
      data_d   = sel_data;
      // R0 is hardwired: the beat is consumed but never written.
      wr_d     = (sel_rd != '0);
      if (lock_ext[grant_idx]) begin
        state_d   = StLock;
        lock_id_d = grant_idx;
      end else begin
        state_d   = StArb;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StArb;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
      wr_q      <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
      gid_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      gid_q     <= gid_d;
    end
  end

  assign wrReg     = wr_q;
  assign rd        = rd_q;
  assign rdIn      = data_q;
  assign grant_id  = gid_q;
  assign pend_mask = wr_q ? (PendW'(1) << rd_q) : '0;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural round-robin/lock model.
module tb_reg_wb_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         wb_en;
  logic [3:0]   req_valid;
  logic [3:0]   req_lock;
  logic [15:0]  req_rd;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         wrReg;
  logic [3:0]   rd;
  logic [31:0]  rdIn;
  logic [2:0]   grant_id;
  logic [15:0]  pend_mask;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_lock, m_ptr, m_lid;
  logic        e_wr;
  logic [3:0]  e_rd;
  logic [31:0] e_data;
  logic [2:0]  e_gid;

  reg_wb_arbiter #(.NREQ(4), .ADDR_W(4), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_en     (wb_en),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wrReg     (wrReg),
    .rd        (rd),
    .rdIn      (rdIn),
    .grant_id  (grant_id),
    .pend_mask (pend_mask)
  );

  always #5 clk = ~clk;

  function automatic int model_grant();
    if (reset || !wb_en) return -1;
    if (m_lock != 0) return req_valid[m_lid] ? m_lid : -1;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = model_grant();
    return (g < 0) ? 4'b0 : 4'(1 << g);
  endfunction

  function automatic logic [15:0] exp_pm();
    return e_wr ? 16'(1 << e_rd) : 16'h0;
  endfunction

  task automatic model_reset();
    m_lock = 0; m_ptr = 0; m_lid = 0;
    e_wr = 1'b0; e_rd = '0; e_data = '0; e_gid = '0;
  endtask

  // Advance one clock and update the model with the beat accepted this cycle.
  task automatic tick();
    int g;
    g = model_grant();
    @(posedge clk);
    if (g >= 0) begin
      e_gid  = 3'(g);
      e_rd   = req_rd[g*4 +: 4];
      e_data = req_data[g*32 +: 32];
      e_wr   = (e_rd != 4'd0);
      m_ptr  = (g + 1) % 4;
      if (req_lock[g]) begin
        m_lock = 1; m_lid = g;
      end else begin
        m_lock = 0;
      end
    end else begin
      e_wr = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; wb_en = 1'b1; req_valid = '0; req_lock = '0; req_rd = '0; req_data = '0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (wrReg !== 1'b0) begin errors++; $display("FAIL rst_wr: got %b exp 0", wrReg); end
      checks++; if (pend_mask !== 16'h0) begin errors++; $display("FAIL rst_pm: got %h exp 0", pend_mask); end
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", req_ready); end
    end
    req_valid = 4'b1111; #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rst_ready_valid: got %b exp 0", req_ready); end
    @(posedge clk); #1;
    req_valid = '0; reset = 1'b0; #1;
    checks++; if (rd !== 4'd0 || rdIn !== 32'd0 || grant_id !== 3'd0) begin
      errors++; $display("FAIL rst_regs: got rd=%h rdIn=%h gid=%0d exp 0", rd, rdIn, grant_id);
    end
    tick();
    checks++; if (wrReg !== 1'b0 || req_ready !== 4'b0) begin
      errors++; $display("FAIL idle: got wr=%b ready=%b exp 0", wrReg, req_ready);
    end
  endtask

  task automatic test_alternate();
    int seq [4] = '{0, 2, 0, 2};
    req_valid = 4'b0101; req_lock = '0;
    req_rd = '0; req_rd[0 +: 4] = 4'd3; req_rd[8 +: 4] = 4'd5;
    req_data = '0; req_data[0 +: 32] = 32'hAA; req_data[64 +: 32] = 32'hBB;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req_ready !== 4'(1 << seq[i])) begin
        errors++; $display("FAIL alt_ready[%0d]: got %b exp %b", i, req_ready, 4'(1 << seq[i]));
      end
      tick();
      if (seq[i] == 0) begin
        checks++; if (wrReg !== 1'b1 || rd !== 4'd3 || rdIn !== 32'hAA || pend_mask !== 16'h0008) begin
          errors++; $display("FAIL alt_out0: got wr=%b rd=%h rdIn=%h pm=%h exp 1/3/AA/0008",
                             wrReg, rd, rdIn, pend_mask);
        end
      end else begin
        checks++; if (wrReg !== 1'b1 || rd !== 4'd5 || rdIn !== 32'hBB || pend_mask !== 16'h0020) begin
          errors++; $display("FAIL alt_out2: got wr=%b rd=%h rdIn=%h pm=%h exp 1/5/BB/0020",
                             wrReg, rd, rdIn, pend_mask);
        end
      end
    end
  endtask

  task automatic test_lock();
    int seq [5] = '{1, 1, 1, 1, 3};
    // One req0 beat moves the pointer to 1 so req1 wins first.
    req_valid = 4'b0001; req_lock = '0; req_rd[0 +: 4] = 4'd1;
    tick();
    req_valid = 4'b1010; req_rd[12 +: 4] = 4'd14; req_data[96 +: 32] = 32'h3333;
    for (int b = 0; b < 5; b++) begin
      req_lock = (b < 3) ? 4'b0010 : 4'b0000;
      req_rd[4 +: 4] = 4'(2 + b); req_data[32 +: 32] = 32'h100 + b;
      #1;
      checks++; if (req_ready !== 4'(1 << seq[b])) begin
        errors++; $display("FAIL lock_ready[%0d]: got %b exp %b", b, req_ready, 4'(1 << seq[b]));
      end
      tick();
      checks++; if (grant_id !== 3'(seq[b]) || wrReg !== 1'b1) begin
        errors++; $display("FAIL lock_gid[%0d]: got gid=%0d wr=%b exp %0d/1", b, grant_id, wrReg, seq[b]);
      end
      if (b < 4) begin
        checks++; if (rd !== 4'(2 + b) || rdIn !== 32'h100 + b) begin
          errors++; $display("FAIL lock_data[%0d]: got rd=%h rdIn=%h exp %h/%h", b, rd, rdIn, 2 + b, 32'h100 + b);
        end
      end
    end
  endtask

  task automatic test_r0();
    req_valid = 4'b0001; req_lock = '0; req_rd[0 +: 4] = 4'd0; req_data[0 +: 32] = 32'hFFFF_FFFF;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL r0_ready: got %b exp 0001", req_ready); end
    tick();
    checks++; if (wrReg !== 1'b0 || pend_mask !== 16'h0 || grant_id !== 3'd0) begin
      errors++; $display("FAIL r0_out: got wr=%b pm=%h gid=%0d exp 0/0/0", wrReg, pend_mask, grant_id);
    end
  endtask

  task automatic test_wb_en();
    req_valid = 4'b0010; req_lock = '0; req_rd[4 +: 4] = 4'd7; req_data[32 +: 32] = 32'h1234;
    wb_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL wben_ready[%0d]: got %b exp 0", i, req_ready); end
      tick();
      checks++; if (wrReg !== 1'b0) begin errors++; $display("FAIL wben_wr[%0d]: got %b exp 0", i, wrReg); end
    end
    wb_en = 1'b1; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wben_resume: got %b exp 0010", req_ready); end
    tick();
    checks++; if (wrReg !== 1'b1 || grant_id !== 3'd1 || rd !== 4'd7 || rdIn !== 32'h1234) begin
      errors++; $display("FAIL wben_out: got wr=%b gid=%0d rd=%h rdIn=%h exp 1/1/7/1234", wrReg, grant_id, rd, rdIn);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wb_en     = ($urandom_range(0, 7) != 0);
      req_valid = 4'($urandom);
      req_lock  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      req_rd    = 16'($urandom);
      req_data  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      checks++; if (req_ready !== exp_ready()) begin
        errors++; $display("FAIL rnd_ready[%0d]: got %b exp %b", i, req_ready, exp_ready());
      end
      tick();
      checks++; if (wrReg !== e_wr || grant_id !== e_gid || pend_mask !== exp_pm()) begin
        errors++; $display("FAIL rnd_out[%0d]: got wr=%b gid=%0d pm=%h exp %b/%0d/%h",
                           i, wrReg, grant_id, pend_mask, e_wr, e_gid, exp_pm());
      end
      if (e_wr) begin
        checks++; if (rd !== e_rd || rdIn !== e_data) begin
          errors++; $display("FAIL rnd_data[%0d]: got rd=%h rdIn=%h exp %h/%h", i, rd, rdIn, e_rd, e_data);
        end
      end
    end
  endtask

  task automatic test_reset_mid_lock();
    wb_en = 1'b1;
    // Release any lock left by random traffic before setting up a fresh one.
    req_valid = 4'b1111; req_lock = '0;
    tick();
    req_valid = 4'b0100; req_lock = 4'b0100; req_rd[8 +: 4] = 4'd9; req_data[64 +: 32] = 32'hCAFE;
    tick();
    checks++; if (wrReg !== 1'b1 || rd !== 4'd9) begin
      errors++; $display("FAIL mid_lock_pre: got wr=%b rd=%h exp 1/9", wrReg, rd);
    end
    reset = 1'b1; #1;
    checks++; if (wrReg !== 1'b0 || pend_mask !== 16'h0 || req_ready !== 4'b0 || rd !== 4'd0) begin
      errors++; $display("FAIL mid_lock_rst: got wr=%b pm=%h ready=%b rd=%h exp 0", wrReg, pend_mask, req_ready, rd);
    end
    @(posedge clk); #1;
    reset = 1'b0; model_reset();
    req_valid = 4'b1111; req_lock = '0; #1;
    checks++; if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL mid_lock_arb: got %b exp 0001", req_ready);
    end
    tick();
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL mid_lock_gid: got %0d exp 0", grant_id); end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_lock();
    test_r0();
    test_wb_en();
    test_random();
    test_reset_mid_lock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
